// File: rtl/axi_rd_burst_splitter.sv
// Breaks upstream AXI read bursts into single-beat downstream reads, one in flight at a time,
// and rebuilds rid/rlast on the way back. Oversized arsize is answered locally with SLVERR beats.
module axi_rd_burst_splitter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [1:0]        s_arburst,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [LEN_W-1:0]  s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [ID_W-1:0]   s_rid,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [1:0]        m_arburst,
    output logic [ID_W-1:0]   m_arid,
    output logic [LEN_W-1:0]  m_arlen,
    output logic [2:0]        m_arsize,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready
);

    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ar_req_t;

    ar_req_t           req_q;
    logic [1:0]        state_q;
    logic [LEN_W-1:0]  beat_q;
    logic              beat_last;

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_nxt;
    logic              wrap_ok;

    // The downstream bridge always asserts rlast, so it carries no information here.
    logic unused_m_rlast;
    assign unused_m_rlast = m_rlast;

    assign beat_last = (beat_q == req_q.len);

    // Wrap window is (len+1)*step bytes; only the bits inside the window advance.
    always_comb begin
        step      = ADDR_W'(1) << req_q.size;
        wrap_mask = ((ADDR_W'(req_q.len) + ADDR_W'(1)) << req_q.size) - ADDR_W'(1);
        addr_inc  = req_q.addr + step;
        wrap_ok   = (req_q.len == LEN_W'(1)) || (req_q.len == LEN_W'(3)) ||
                    (req_q.len == LEN_W'(7)) || (req_q.len == LEN_W'(15));
        addr_nxt  = addr_inc;
        if (req_q.burst == BURST_FIXED)
            addr_nxt = req_q.addr;
        else if (req_q.burst == BURST_WRAP && wrap_ok)
            addr_nxt = (req_q.addr & ~wrap_mask) | (addr_inc & wrap_mask);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            req_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (s_arvalid) begin
                        req_q   <= '{addr: s_araddr, id: s_arid, len: s_arlen,
                                     size: s_arsize, burst: s_arburst};
                        beat_q  <= '0;
                        state_q <= (s_arsize <= 3'(MAX_SIZE)) ? S_ISSUE : S_ERR;
                    end
                end
                S_ISSUE: begin
                    if (m_arready)
                        state_q <= S_WAIT_R;
                end
                S_WAIT_R: begin
                    if (m_rvalid && s_rready) begin
                        if (beat_last) begin
                            state_q <= S_IDLE;
                        end else begin
                            beat_q     <= beat_q + 1'b1;
                            req_q.addr <= addr_nxt;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                S_ERR: begin
                    if (s_rready) begin
                        if (beat_last)
                            state_q <= S_IDLE;
                        else
                            beat_q <= beat_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_arready = (state_q == S_IDLE);

    assign m_arvalid = (state_q == S_ISSUE);
    assign m_araddr  = req_q.addr;
    assign m_arburst = 2'b01;
    assign m_arid    = '0;
    assign m_arlen   = '0;
    assign m_arsize  = req_q.size;
    assign m_rready  = (state_q == S_WAIT_R) && s_rready;

    always_comb begin
        s_rvalid = 1'b0;
        s_rdata  = '0;
        s_rresp  = 2'b00;
        s_rlast  = 1'b0;
        case (state_q)
            S_WAIT_R: begin
                s_rvalid = m_rvalid;
                s_rdata  = m_rdata;
                s_rresp  = m_rresp;
                s_rlast  = beat_last;
            end
            S_ERR: begin
                s_rvalid = 1'b1;
                s_rresp  = RESP_SLVERR;
                s_rlast  = beat_last;
            end
            default: ;
        endcase
    end

    assign s_rid = req_q.id;

endmodule

// File: tb/tb_axi_rd_burst_splitter.sv
// Scoreboard bench: stimulus pushes expected downstream addresses and upstream beats,
// independent monitors pop and compare on each handshake. Includes a 1-cycle SRAM bridge model.
module tb_axi_rd_burst_splitter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 4;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [ADDR_W-1:0] s_araddr;
    logic [1:0]        s_arburst;
    logic [ID_W-1:0]   s_arid;
    logic [LEN_W-1:0]  s_arlen;
    logic [2:0]        s_arsize;
    logic              s_arvalid;
    logic              s_arready;
    logic [DATA_W-1:0] s_rdata;
    logic [ID_W-1:0]   s_rid;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              s_rvalid;
    logic              s_rready;
    logic [ADDR_W-1:0] m_araddr;
    logic [1:0]        m_arburst;
    logic [ID_W-1:0]   m_arid;
    logic [LEN_W-1:0]  m_arlen;
    logic [2:0]        m_arsize;
    logic              m_arvalid;
    logic              m_arready;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rvalid;
    logic              m_rready;

    axi_rd_burst_splitter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_araddr(s_araddr), .s_arburst(s_arburst), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_araddr(m_araddr), .m_arburst(m_arburst), .m_arid(m_arid), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 aclk = ~aclk;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    int checks = 0;
    int errors = 0;
    int r_cnt  = 0;
    logic [31:0] exp_ar[$];
    logic [38:0] exp_r[$];
    logic        err_win   = 1'b0;
    logic        ar_in_err = 1'b0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] id, input logic last);
        exp_ar.push_back(a);
        exp_r.push_back({data_of(a), id, 2'b00, last});
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [1:0] b, input logic [3:0] id,
                         input logic [3:0] len, input logic [2:0] size);
        logic done;
        done = 1'b0;
        @(posedge aclk); #1;
        s_araddr = a; s_arburst = b; s_arid = id; s_arlen = len; s_arsize = size;
        s_arvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge aclk);
            if (s_arready) done = 1'b1;
        end
        #1 s_arvalid = 1'b0;
        if (!done) chk("ar_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge aclk);
            if (exp_ar.size() == 0 && exp_r.size() == 0) done = 1'b1;
        end
        if (!done) chk("burst_timeout", 64'(exp_r.size()), 64'd0);
    endtask

    task automatic wait_beats(input int n);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge aclk);
            if (r_cnt >= n) done = 1'b1;
        end
        if (!done) chk("beat_timeout", 64'(r_cnt), 64'(n));
    endtask

    // 1-cycle SRAM bridge: data appears the cycle after the AR handshake, held until rready.
    initial begin
        logic ar_hs, r_hs, rst_s;
        logic [31:0] a;
        m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b1;
        forever begin
            @(posedge aclk);
            ar_hs = m_arvalid && m_arready;
            r_hs  = m_rvalid && m_rready;
            rst_s = aresetn;
            a     = m_araddr;
            #1;
            if (!rst_s) begin
                m_rvalid = 1'b0;
            end else begin
                if (r_hs) m_rvalid = 1'b0;
                if (ar_hs) begin
                    m_rvalid = 1'b1;
                    m_rdata  = data_of(a);
                    m_rresp  = 2'b00;
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn && m_arvalid && m_arready) begin
            if (exp_ar.size() == 0) chk("unexpected_m_ar", 64'(m_araddr), 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("m_araddr", {m_arvalid, m_arlen, m_arburst, m_arid, m_araddr},
                     {1'b1, 4'd0, 2'b01, 4'd0, exp_ar.pop_front()});
        end
    end

    always @(negedge aclk) begin
        if (aresetn && s_rvalid && s_rready) begin
            r_cnt++;
            if (exp_r.size() == 0) chk("unexpected_s_r", 64'(s_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("s_r_beat", {s_rdata, s_rid, s_rresp, s_rlast}, exp_r.pop_front());
        end
    end

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = '0;
    always @(negedge aclk) begin
        if (aresetn && prev_stall) chk("ar_hold", {m_arvalid, m_araddr}, {1'b1, prev_addr});
        prev_stall = aresetn && m_arvalid && !m_arready;
        prev_addr  = m_araddr;
        if (err_win && m_arvalid) ar_in_err = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        aresetn = 1'b0; s_arvalid = 1'b0; s_araddr = '0; s_arburst = '0; s_arid = '0;
        s_arlen = '0; s_arsize = '0; s_rready = 1'b1; m_arready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_state", {s_arready, m_arvalid, s_rvalid, m_rready}, 4'b1000);
        @(posedge aclk); #1 aresetn = 1'b1;

        // single beat
        push_beat(32'h100, 4'd5, 1'b1);
        do_ar(32'h100, INCR, 4'd5, 4'd0, 3'd2);
        wait_done();

        // INCR len=3 with a downstream arready stall on the first beat
        push_beat(32'h1000, 4'd3, 1'b0); push_beat(32'h1004, 4'd3, 1'b0);
        push_beat(32'h1008, 4'd3, 1'b0); push_beat(32'h100C, 4'd3, 1'b1);
        m_arready = 1'b0;
        do_ar(32'h1000, INCR, 4'd3, 4'd3, 3'd2);
        repeat (3) @(posedge aclk);
        #1 m_arready = 1'b1;
        wait_done();

        // WRAP len=3
        push_beat(32'h1008, 4'd1, 1'b0); push_beat(32'h100C, 4'd1, 1'b0);
        push_beat(32'h1000, 4'd1, 1'b0); push_beat(32'h1004, 4'd1, 1'b1);
        do_ar(32'h1008, WRAP, 4'd1, 4'd3, 3'd2);
        wait_done();

        // FIXED len=2, then INCR across the top of the address space
        push_beat(32'h20, 4'd2, 1'b0); push_beat(32'h20, 4'd2, 1'b0); push_beat(32'h20, 4'd2, 1'b1);
        do_ar(32'h20, FIXED, 4'd2, 4'd2, 3'd2);
        wait_done();
        push_beat(32'hFFFF_FFFC, 4'd4, 1'b0); push_beat(32'h0, 4'd4, 1'b1);
        do_ar(32'hFFFF_FFFC, INCR, 4'd4, 4'd1, 3'd2);
        wait_done();

        // upstream backpressure on beat 2
        begin
            int base;
            logic seen;
            base = r_cnt;
            seen = 1'b0;
            push_beat(32'h2000, 4'd7, 1'b0); push_beat(32'h2004, 4'd7, 1'b0);
            push_beat(32'h2008, 4'd7, 1'b0); push_beat(32'h200C, 4'd7, 1'b1);
            do_ar(32'h2000, INCR, 4'd7, 4'd3, 3'd2);
            wait_beats(base + 1);
            @(posedge aclk); #1 s_rready = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge aclk);
                if (s_rvalid) seen = 1'b1;
            end
            for (int i = 0; i < 5; i++) begin
                chk("bp_hold", {s_rvalid, s_rdata, m_arvalid, s_arready},
                    {1'b1, data_of(32'h2004), 1'b0, 1'b0});
                @(negedge aclk);
            end
            @(posedge aclk); #1 s_rready = 1'b1;
            wait_done();
        end

        // oversized arsize answered with SLVERR, nothing sent downstream
        err_win = 1'b1;
        exp_r.push_back({32'h0, 4'd9, 2'b10, 1'b0});
        exp_r.push_back({32'h0, 4'd9, 2'b10, 1'b1});
        do_ar(32'h300, INCR, 4'd9, 4'd1, 3'd3);
        wait_done();
        @(negedge aclk);
        err_win = 1'b0;
        chk("err_no_m_ar", 64'(ar_in_err), 64'd0);

        // reset mid-burst
        begin
            int base;
            base = r_cnt;
            push_beat(32'h400, 4'd2, 1'b0); push_beat(32'h404, 4'd2, 1'b0);
            push_beat(32'h408, 4'd2, 1'b0); push_beat(32'h40C, 4'd2, 1'b1);
            do_ar(32'h400, INCR, 4'd2, 4'd3, 3'd2);
            wait_beats(base + 1);
            @(posedge aclk); #1 aresetn = 1'b0;
            exp_ar.delete();
            exp_r.delete();
            @(negedge aclk);
            chk("reset_mid_burst", {s_arready, m_arvalid, s_rvalid, m_rready}, 4'b1000);
            @(posedge aclk); #1 aresetn = 1'b1;
        end

        // recovery after reset
        push_beat(32'h500, 4'd6, 1'b0); push_beat(32'h504, 4'd6, 1'b1);
        do_ar(32'h500, INCR, 4'd6, 4'd1, 3'd2);
        wait_done();

        repeat (3) @(negedge aclk);
        chk("idle_at_end", {s_arready, m_arvalid, s_rvalid}, 3'b100);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
